// File: rtl/ifu_pkg.sv
// ifu_pkg: shared fetch FSM states and RVC opcode helpers for the IFU
package ifu_pkg;
  typedef enum logic [1:0] {S_EVAL, S_REQ, S_RSP} fetch_state_e;
  localparam logic [1:0] RVC_OPCODE_FULL = 2'b11;
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != RVC_OPCODE_FULL;
  endfunction
endpackage

// File: rtl/fetch_aligner.sv
// fetch_aligner: fetches 32-bit words and extracts the RVC/32-bit instruction at curr_pc
module fetch_aligner
  import ifu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] curr_pc,
  input  logic            je,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            compressed,
  output logic            stall
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] need_addr_q, need_addr_d;
  logic            drop_q, drop_d;
  logic [31:0]     buf_data_q, buf_data_d;
  logic [XLEN-1:2] buf_tag_q, buf_tag_d;
  logic            buf_valid_q, buf_valid_d;
  logic [15:0]     spill_hw_q, spill_hw_d;
  logic [XLEN-1:2] spill_tag_q, spill_tag_d;
  logic            spill_valid_q, spill_valid_d;
  logic [XLEN-1:2] w, w_nxt;
  logic            h, eval, hit, lo_rvc, hi_rvc, sel_lo, sel_hi, sel_st, hs, pc_unused;

  assign w         = curr_pc[XLEN-1:2];
  assign h         = curr_pc[1];
  assign pc_unused = curr_pc[0];
  assign w_nxt     = w + (XLEN-2)'(1);
  assign eval      = state_q == S_EVAL;
  assign hit       = buf_valid_q && buf_tag_q == w;
  assign lo_rvc    = is_rvc(buf_data_q[15:0]);
  assign hi_rvc    = is_rvc(buf_data_q[31:16]);
  assign sel_lo    = eval && hit && !h;
  assign sel_hi    = eval && hit && h && hi_rvc;
  // buf holds the upper word of a straddle; spill holds the lower half
  assign sel_st    = eval && h && spill_valid_q && spill_tag_q == w && buf_valid_q && buf_tag_q == w_nxt;

  assign instr_valid   = sel_lo || sel_hi || sel_st;
  assign compressed    = sel_lo ? lo_rvc : sel_hi;
  assign instr         = sel_lo ? (lo_rvc ? {16'h0, buf_data_q[15:0]} : buf_data_q) :
                         sel_hi ? {16'h0, buf_data_q[31:16]} :
                         sel_st ? {buf_data_q[15:0], spill_hw_q} : 32'h0;
  assign hs            = instr_valid && instr_ready;
  assign stall         = !hs;
  assign mem_req_valid = state_q == S_REQ;
  assign mem_req_addr  = need_addr_q;

  always_comb begin
    state_d       = state_q;
    need_addr_d   = need_addr_q;
    drop_d        = drop_q;
    buf_data_d    = buf_data_q;
    buf_tag_d     = buf_tag_q;
    buf_valid_d   = buf_valid_q;
    spill_hw_d    = spill_hw_q;
    spill_tag_d   = spill_tag_q;
    spill_valid_d = spill_valid_q;
    case (state_q)
      S_EVAL: if (!je && !instr_valid) begin
        if (hit && h) begin
          spill_hw_d    = buf_data_q[31:16];
          spill_tag_d   = w;
          spill_valid_d = 1'b1;
          need_addr_d   = {w_nxt, 2'b00};
        end else begin
          need_addr_d = {w, 2'b00};
        end
        state_d = S_REQ;
      end
      S_REQ: begin
        drop_d  = drop_q || je;
        state_d = mem_req_ready ? S_RSP : S_REQ;
      end
      S_RSP: if (mem_rsp_valid) begin
        if (!drop_q && !je) begin
          buf_data_d  = mem_rsp_data;
          buf_tag_d   = need_addr_q[XLEN-1:2];
          buf_valid_d = 1'b1;
        end
        drop_d  = 1'b0;
        state_d = S_EVAL;
      end else begin
        drop_d = drop_q || je;
      end
      default: state_d = S_EVAL;
    endcase
    if (hs || je) spill_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_EVAL;
      need_addr_q   <= '0;
      drop_q        <= 1'b0;
      buf_data_q    <= '0;
      buf_tag_q     <= '0;
      buf_valid_q   <= 1'b0;
      spill_hw_q    <= '0;
      spill_tag_q   <= '0;
      spill_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      need_addr_q   <= need_addr_d;
      drop_q        <= drop_d;
      buf_data_q    <= buf_data_d;
      buf_tag_q     <= buf_tag_d;
      buf_valid_q   <= buf_valid_d;
      spill_hw_q    <= spill_hw_d;
      spill_tag_q   <= spill_tag_d;
      spill_valid_q <= spill_valid_d;
    end
  end
endmodule
